data_demodulate_9x9: RTL and testbench

Reassembles the filtered output of the 9x9 window core into a full-frame raster stream. The 9x9 data modulate stage delivers one result per interior pixel only. This block re-inserts the 4-pixel border on every side and buffers interior results in a small FIFO, so the core may run ahead of the raster. It sits between the 9x9 filter core and the output/writeback stage, and signals frame completion with `done_o`.

---
 rtl/data_demodulate_9x9.sv | 191 +++++++++++++++++++
 tb/tb_data_demodulate_9x9.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_demodulate_9x9.sv
// data_demodulate_9x9: rebuilds a full raster frame from interior 9x9 results,
// filling the 4-pixel border. Optional build macro: DATA_DEMOD_9X9_UNDERFLOW_EN.
module data_demodulate_9x9 #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS = 480,
    parameter int COLS = 640,
    parameter int FIFO_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] BORDER_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    input  logic                  done_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(4);
    localparam logic [ROW_W-1:0] ROW_HI   = ROW_W'(ROWS - 5);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LO   = COL_W'(4);
    localparam logic [COL_W-1:0] COL_HI   = COL_W'(COLS - 5);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        col;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    done_seen;

    logic                    in_run;
    logic                    border;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    emit;
    logic                    last_pos;
    logic                    underflow;
    logic                    accept_start;

    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic                    done_p1;

    function automatic logic is_border(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return (r < ROW_LO) || (r > ROW_HI) || (c < COL_LO) || (c > COL_HI);
    endfunction

    assign in_run       = (state == RUN);
    assign accept_start = (state == IDLE) && start;
    assign border       = is_border(row, col);
    assign fifo_empty   = (count == '0);
    assign ready_o      = in_run && (count != CNT_FULL);
    assign push         = valid_i && ready_o;
    // Interior positions only advance once the core has delivered their word.
    assign pop          = in_run && !border && !fifo_empty;
    assign emit         = in_run && (border || !fifo_empty);
    assign last_pos     = (row == ROW_LAST) && (col == COL_LAST);

`ifdef DATA_DEMOD_9X9_UNDERFLOW_EN
    logic error_q;

    assign underflow = in_run && !border && fifo_empty && done_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (accept_start) begin
            error_q <= 1'b0;
        end else if (underflow) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    logic unused_done_seen;

    assign underflow        = 1'b0;
    assign error_o          = 1'b0;
    assign unused_done_seen = done_seen;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if ((emit && last_pos) || underflow) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (accept_start) begin
            row <= '0;
            col <= '0;
        end else if (emit) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= last_pos ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_seen <= 1'b0;
        end else if (accept_start || (state == DONE)) begin
            done_seen <= 1'b0;
        end else if (in_run && done_i) begin
            done_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == DONE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    // p1: registered output stage, one cycle after the emit decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= emit;
            done_p1 <= (state == DONE);
            if (emit) data_p1 <= border ? BORDER_VALUE : mem[rd_ptr];
        end
    end

    assign valid_o = vld_p1;
    assign data_o  = data_p1;
    assign done_o  = done_p1;

endmodule

// File: tb/tb_data_demodulate_9x9.sv
// Directed bench for data_demodulate_9x9 on a 10x12 frame with a 4-deep FIFO.
module tb_data_demodulate_9x9;

    localparam int DW    = 8;
    localparam int ROWS  = 10;
    localparam int COLS  = 12;
    localparam int DEPTH = 4;
    localparam int FRAME = ROWS * COLS;

    logic          clk;
    logic          rst;
    logic          start;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          done_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          done_o;
    logic          error_o;

    int checks;
    int failures;
    int beats, gaps, first_beat, last_beat, done_cyc, done_cnt;
    int drop_pushes, rise_beats, err_seen;

    data_demodulate_9x9 #(
        .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH), .BORDER_VALUE('0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .done_i(done_i), .valid_o(valid_o), .data_o(data_o),
        .done_o(done_o), .error_o(error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame: drives start, offers values 1..n_vals, records every output cycle.
    task automatic run_frame(input int n_vals, input int hold_idx, input bit early,
                             input bit pulse_done, input int inj_cyc,
                             input int stop_beats, input int max_cyc);
        int idx;
        bit pushed, prev_ready, done_sent;
        int r, c;
        logic [DW-1:0] expd;
        idx = 0; done_sent = 0;
        beats = 0; gaps = 0; first_beat = -1; last_beat = -1; done_cyc = -1; done_cnt = 0;
        drop_pushes = -1; rise_beats = -1; err_seen = 0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            start   = (cyc == 0) || (cyc == inj_cyc);
            valid_i = (idx < n_vals) && (cyc > 0 || early) && !(idx == hold_idx && gaps < 19);
            data_i  = DW'(idx + 1);
            done_i  = pulse_done && (idx == n_vals) && !done_sent;
            pushed     = valid_i && ready_o;
            prev_ready = ready_o;
            @(posedge clk);
            #1;
            if (pushed) idx++;
            if (done_i) done_sent = 1;
            if (valid_o) begin
                r = beats / COLS;
                c = beats % COLS;
                expd = (r >= 4 && r <= ROWS - 5 && c >= 4 && c <= COLS - 5) ?
                       DW'((r - 4) * (COLS - 8) + (c - 4) + 1) : '0;
                chk($sformatf("beat_data[%0d]", beats), data_o, expd);
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                beats++;
            end else if (beats > 0 && beats < FRAME) begin
                gaps++;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (error_o) err_seen = 1;
            if (prev_ready && !ready_o && drop_pushes < 0) drop_pushes = idx;
            if (!prev_ready && ready_o && drop_pushes >= 0 && rise_beats < 0) rise_beats = beats;
            if (stop_beats > 0 && beats >= stop_beats) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0; valid_i = 1'b0; done_i = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; valid_i = 1'b0; data_i = '0; done_i = 1'b0;
        #12;
        chk("reset_valid", valid_o, 0);
        chk("reset_data", data_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_error", error_o, 0);
        chk("reset_ready", ready_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("idle_ready", ready_o, 0);

        // Full frame, no backpressure
        run_frame(8, -1, 1'b0, 1'b0, -1, 0, 300);
        chk("a_beats", beats, FRAME);
        chk("a_first_beat", first_beat, 1);
        chk("a_last_beat", last_beat, FRAME);
        chk("a_done_cyc", done_cyc, FRAME + 1);
        chk("a_done_cnt", done_cnt, 1);
        chk("a_gaps", gaps, 0);
        chk("a_error", err_seen, 0);

        // FIFO fills from the start cycle
        run_frame(8, -1, 1'b1, 1'b0, -1, 0, 300);
        chk("b_drop_pushes", drop_pushes, DEPTH);
        chk("b_rise_beats", rise_beats, 4 * COLS + 4 + 1);
        chk("b_beats", beats, FRAME);
        chk("b_done_cyc", done_cyc, last_beat + 1);
        chk("b_done_cnt", done_cnt, 1);

        // Value for (5,6) withheld
        run_frame(8, 6, 1'b0, 1'b0, -1, 0, 300);
        chk("c_gaps", gaps, 20);
        chk("c_beats", beats, FRAME);
        chk("c_last_beat", last_beat, FRAME + 20);
        chk("c_done_cyc", done_cyc, last_beat + 1);
        chk("c_done_cnt", done_cnt, 1);

        // Only 5 values, then done_i
`ifdef DATA_DEMOD_9X9_UNDERFLOW_EN
        run_frame(5, -1, 1'b0, 1'b1, -1, 0, 200);
        chk("d_beats", beats, 5 * COLS + 5);
        chk("d_error", err_seen, 1);
        chk("d_done_cnt", done_cnt, 1);
        chk("d_done_cyc", done_cyc, last_beat + 2);
        chk("d_idle_ready", ready_o, 0);
        chk("d_error_held", error_o, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("d_error_cleared", error_o, 0);
        chk("d_run_ready", ready_o, 1);
`else
        run_frame(5, -1, 1'b0, 1'b1, -1, 0, 150);
        chk("d_beats", beats, 5 * COLS + 5);
        chk("d_error", err_seen, 0);
        chk("d_done_cnt", done_cnt, 0);
        chk("d_stalled_ready", ready_o, 1);
`endif
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset mid-frame with interior data on the output
        run_frame(8, -1, 1'b0, 1'b0, -1, 4 * COLS + 4 + 4, 300);
        chk("e_pre_data", data_o, 4);
        #2 rst = 1'b1;
        #1;
        chk("e_valid", valid_o, 0);
        chk("e_data", data_o, 0);
        chk("e_done", done_o, 0);
        chk("e_error", error_o, 0);
        chk("e_ready", ready_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // start pulsed again mid-frame is ignored
        run_frame(8, -1, 1'b0, 1'b0, 30, 0, 300);
        chk("f_beats", beats, FRAME);
        chk("f_last_beat", last_beat, FRAME);
        chk("f_done_cyc", done_cyc, FRAME + 1);
        chk("f_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
